pipeline_ctrl: RTL and testbench

Hazard and pipeline-sequencing controller for the 5-stage core. It generates the 2-bit p_ctrl word (bit0 = hold, bit1 = bubble) consumed by the if_id, id_ex, ex_mem and mem_wb stage registers, plus the PC hold and the EX-stage operand-forwarding selects. It owns:
- the post-reset pipeline flush sequence,
- load-use interlock,
- branch/jump redirect squash,
- the data-memory req/ack wait handshake with timeout.

---
 rtl/pipeline_ctrl_pkg.sv | 24 ++
 rtl/pipeline_ctrl_fwd_unit.sv | 21 ++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: p_ctrl words, forwarding selects, FSM states.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // p_ctrl: bit0 = hold, bit1 = bubble; 2'b11 is never driven
  localparam logic [1:0] P_RUN    = 2'b00;
  localparam logic [1:0] P_HOLD   = 2'b01;
  localparam logic [1:0] P_BUBBLE = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // x0 never creates a dependency
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// EX operand forwarding select for one source register; MEM result beats WB result.
module fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && reg_hit(mem_rd, ex_rs))
      sel = FWD_MEM;
    else if (wb_reg_write && reg_hit(wb_rd, ex_rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: post-reset flush, load-use interlock, redirect squash, dmem wait with timeout.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined; otherwise they read 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_hold,
  output logic [1:0]  if_id_ctrl,
  output logic [1:0]  id_ex_ctrl,
  output logic [1:0]  ex_mem_ctrl,
  output logic [1:0]  mem_wb_ctrl,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  if (XLEN < 1 || INIT_CYCLES < 1 || INIT_CYCLES > 15 ||
      MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_param_chk
    $error("pipeline_ctrl: parameter out of range");
  end

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] TMO       = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TMO_M1    = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] init_cnt;
  logic [7:0] wait_cnt;
  logic       active, mem_stall, load_use, redirect_cyc;
  logic [1:0] fwd1, fwd2;

  assign active    = ~reset & (state != ST_INIT);
  assign mem_stall = dmem_req & ~dmem_ack;
  assign load_use  = ex_mem_read &
                     ((id_rs1_used & reg_hit(ex_rd, id_rs1)) |
                      (id_rs2_used & reg_hit(ex_rd, id_rs2)));

  always_comb begin
    pc_hold      = 1'b1;
    if_id_ctrl   = P_BUBBLE;
    id_ex_ctrl   = P_BUBBLE;
    ex_mem_ctrl  = P_BUBBLE;
    mem_wb_ctrl  = P_BUBBLE;
    redirect_cyc = 1'b0;
    if (active) begin
      pc_hold     = 1'b0;
      if_id_ctrl  = P_RUN;
      id_ex_ctrl  = P_RUN;
      ex_mem_ctrl = P_RUN;
      mem_wb_ctrl = P_RUN;
      // A memory stall freezes the upstream stages, so redirect/load-use inputs stay valid for later
      if (mem_stall) begin
        pc_hold     = 1'b1;
        if_id_ctrl  = P_HOLD;
        id_ex_ctrl  = P_HOLD;
        ex_mem_ctrl = P_HOLD;
        mem_wb_ctrl = P_BUBBLE;
      end else if (ex_redirect) begin
        redirect_cyc = 1'b1;
        if_id_ctrl   = P_BUBBLE;
        id_ex_ctrl   = P_BUBBLE;
      end else if (load_use) begin
        pc_hold    = 1'b1;
        if_id_ctrl = P_HOLD;
        id_ex_ctrl = P_BUBBLE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:     if (init_cnt == 4'd0) state_nxt = ST_RUN;
      ST_RUN:      if (mem_stall) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!mem_stall) state_nxt = ST_RUN;
      default:     state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= INIT_LOAD;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT && init_cnt != 4'd0)
        init_cnt <= init_cnt - 4'd1;
      if (state == ST_RUN && mem_stall)
        wait_cnt <= 8'd0;
      else if (state == ST_MEM_WAIT && mem_stall && wait_cnt != TMO)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == ST_MEM_WAIT && mem_stall && wait_cnt >= TMO_M1)
        mem_err <= 1'b1;
    end
  end

  fwd_unit u_fwd_rs1 (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd1)
  );

  fwd_unit u_fwd_rs2 (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd2)
  );

  assign fwd_rs1_sel = reset ? FWD_RF : fwd1;
  assign fwd_rs2_sel = reset ? FWD_RF : fwd2;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (active && pc_hold) stall_q <= stall_q + 32'd1;
      if (redirect_cyc)      flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed table, corner sequences, then random stimulus against a reference model.
module tb_pipeline_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam logic [7:0] BUB    = 8'b10_10_10_10;
  localparam logic [7:0] RUNC   = 8'b00_00_00_00;
  localparam logic [7:0] STALLM = 8'b01_01_01_10;
  localparam logic [7:0] LU     = 8'b01_10_00_00;
  localparam logic [7:0] RD     = 8'b10_10_00_00;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect;
  logic        mem_reg_write, wb_reg_write, dmem_req, dmem_ack;
  logic        pc_hold, mem_err;
  logic [1:0]  if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  pipeline_ctrl #(.XLEN(32), .INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_hold(pc_hold), .if_id_ctrl(if_id_ctrl), .id_ex_ctrl(id_ex_ctrl),
    .ex_mem_ctrl(ex_mem_ctrl), .mem_wb_ctrl(mem_wb_ctrl),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: "init cycles still owed" and "consecutive stalled cycles" instead of an FSM
  int          init_left = INIT_CYCLES;
  int          streak    = 0;
  logic        m_err     = 1'b0;
  logic [31:0] m_scnt    = 32'd0;
  logic [31:0] m_fcnt    = 32'd0;
  logic        m_hold;
  logic [7:0]  m_ctrl;
  logic [1:0]  m_f1, m_f2;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs)    return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic stall_in();
    return dmem_req && !dmem_ack;
  endfunction

  task automatic model_eval();
    logic lu;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    m_f1 = fwd_ref(ex_rs1);
    m_f2 = fwd_ref(ex_rs2);
    if (reset) begin
      m_hold = 1'b1; m_ctrl = BUB; m_f1 = 2'b00; m_f2 = 2'b00;
    end else if (init_left > 0) begin
      m_hold = 1'b1; m_ctrl = BUB;
    end else if (stall_in()) begin
      m_hold = 1'b1; m_ctrl = STALLM;
    end else if (ex_redirect) begin
      m_hold = 1'b0; m_ctrl = RD;
    end else if (lu) begin
      m_hold = 1'b1; m_ctrl = LU;
    end else begin
      m_hold = 1'b0; m_ctrl = RUNC;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      init_left = INIT_CYCLES; streak = 0; m_err = 1'b0;
      m_scnt = 32'd0; m_fcnt = 32'd0;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
`ifdef PIPE_PERF_CNT_EN
      if (m_hold) m_scnt = m_scnt + 32'd1;
      if (!stall_in() && ex_redirect) m_fcnt = m_fcnt + 32'd1;
`endif
      streak = stall_in() ? streak + 1 : 0;
      // the first stalled cycle is the entry cycle; MEM_TIMEOUT more waiting cycles raise the error
      if (streak > MEM_TIMEOUT) m_err = 1'b1;
    end
  endtask

  function automatic logic [13:0] mk(input logic h, input logic [7:0] c,
                                     input logic [1:0] f1, input logic [1:0] f2, input logic e);
    return {h, c, f1, f2, e};
  endfunction

  task automatic step(input string name, input bit use_hand, input logic [13:0] hand);
    logic [13:0] act14;
    logic [77:0] act, exp;
    @(negedge clock);
    model_eval();
    act14 = {pc_hold, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, fwd_rs1_sel, fwd_rs2_sel, mem_err};
    act   = {act14, stall_cnt, flush_cnt};
    exp   = {m_hold, m_ctrl, m_f1, m_f2, m_err, m_scnt, m_fcnt};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s model: got %h want %h", name, act, exp);
    if (use_hand) begin
      n_checks++;
      if (act14 === hand) n_pass++;
      else $display("FAIL %s directed: got %b want %b", name, act14, hand);
    end
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect} = '0;
    {mem_reg_write, wb_reg_write, dmem_req, dmem_ack} = '0;
  endtask

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       u1, u2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mr, redir;
    logic [4:0] mem_rd;
    logic       mw;
    logic [4:0] wb_rd;
    logic       ww, req, ack;
    logic [13:0] exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, RUNC, 0, 0, 0)};
    vt[1]  = '{5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, mk(1, LU,   0, 0, 0)};
    vt[2]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, mk(0, RUNC, 0, 0, 0)};
    vt[3]  = '{0, 9, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, mk(1, LU,   0, 0, 0)};
    vt[4]  = '{0, 9, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, mk(0, RUNC, 0, 0, 0)};
    vt[5]  = '{5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, mk(0, RD,   0, 0, 0)};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, mk(0, RD,   0, 0, 0)};
    vt[7]  = '{0, 0, 0, 0, 7, 3, 0, 0, 0, 7, 1, 7, 1, 0, 0, mk(0, RUNC, 1, 0, 0)};
    vt[8]  = '{0, 0, 0, 0, 7, 3, 0, 0, 0, 7, 0, 7, 1, 0, 0, mk(0, RUNC, 2, 0, 0)};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, mk(0, RUNC, 0, 0, 0)};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, RUNC, 0, 0, 0)};
    vt[11] = '{0, 0, 0, 0, 4, 12, 0, 0, 0, 12, 1, 12, 1, 0, 0, mk(0, RUNC, 0, 1, 0)};
    vt[12] = '{5, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, RUNC, 0, 0, 0)};

    clear_inputs();
    reset = 1'b1;

    // Reset for two cycles, then exactly INIT_CYCLES bubbles
    step("reset_0", 1, mk(1, BUB, 0, 0, 0));
    step("reset_1", 1, mk(1, BUB, 0, 0, 0));
    reset = 1'b0;
    for (int i = 0; i < INIT_CYCLES; i++) step($sformatf("init_%0d", i), 1, mk(1, BUB, 0, 0, 0));
    step("init_done", 1, mk(0, RUNC, 0, 0, 0));

    for (int i = 0; i < 13; i++) begin
      id_rs1 = vt[i].id_rs1; id_rs2 = vt[i].id_rs2;
      id_rs1_used = vt[i].u1; id_rs2_used = vt[i].u2;
      ex_rs1 = vt[i].ex_rs1; ex_rs2 = vt[i].ex_rs2; ex_rd = vt[i].ex_rd;
      ex_mem_read = vt[i].mr; ex_redirect = vt[i].redir;
      mem_rd = vt[i].mem_rd; mem_reg_write = vt[i].mw;
      wb_rd = vt[i].wb_rd; wb_reg_write = vt[i].ww;
      dmem_req = vt[i].req; dmem_ack = vt[i].ack;
      step($sformatf("table_%0d", i), 1, vt[i].exp);
    end
    clear_inputs();

    // Three-cycle memory wait with a redirect that must be ignored, then the ack cycle runs
    dmem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("memwait_%0d", i), 1, mk(1, STALLM, 0, 0, 0));
    dmem_ack = 1'b1; ex_redirect = 1'b0;
    step("memwait_ack", 1, mk(0, RUNC, 0, 0, 0));
    clear_inputs();
    step("memwait_after", 1, mk(0, RUNC, 0, 0, 0));

    // Timeout: error visible once MEM_TIMEOUT waiting cycles follow the entry cycle
    dmem_req = 1'b1;
    for (int k = 1; k <= 7; k++)
      step($sformatf("timeout_%0d", k), 1, mk(1, STALLM, 0, 0, k > MEM_TIMEOUT + 1));
    dmem_ack = 1'b1;
    step("timeout_ack", 1, mk(0, RUNC, 0, 0, 1));
    clear_inputs();
    step("timeout_sticky", 1, mk(0, RUNC, 0, 0, 1));
    reset = 1'b1;
    step("timeout_rst", 1, mk(1, BUB, 0, 0, 1));
    reset = 1'b0;
    step("timeout_clr", 1, mk(1, BUB, 0, 0, 0));
    for (int i = 1; i < INIT_CYCLES; i++) step("timeout_init", 1, mk(1, BUB, 0, 0, 0));
    step("timeout_run", 1, mk(0, RUNC, 0, 0, 0));

    // Reset in the middle of a wait: full init sequence, pending wait discarded
    dmem_req = 1'b1;
    step("midwait_0", 1, mk(1, STALLM, 0, 0, 0));
    step("midwait_1", 1, mk(1, STALLM, 0, 0, 0));
    reset = 1'b1;
    step("midwait_rst", 1, mk(1, BUB, 0, 0, 0));
    reset = 1'b0;
    for (int i = 0; i < INIT_CYCLES; i++) step("midwait_init", 1, mk(1, BUB, 0, 0, 0));
    step("midwait_restall", 1, mk(1, STALLM, 0, 0, 0));
    dmem_ack = 1'b1;
    step("midwait_ack", 1, mk(0, RUNC, 0, 0, 0));
    clear_inputs();

    for (int n = 0; n < 2500; n++) begin
      reset         = ($urandom_range(0, 199) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_rs1_used   = 1'($urandom_range(0, 1));
      id_rs2_used   = 1'($urandom_range(0, 1));
      ex_rs1        = 5'($urandom_range(0, 3));
      ex_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_mem_read   = 1'($urandom_range(0, 1));
      ex_redirect   = ($urandom_range(0, 4) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      dmem_req      = ($urandom_range(0, 2) != 0);
      dmem_ack      = ($urandom_range(0, 2) == 0);
      step("random", 0, 14'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
